// File: rtl/serial_alu_slave_if.sv
// Serial link between the mini serial processor (master) and the ALU slave.
// nss is active low; miso is driven only by the slave.
interface serial_alu_slave_if;
    logic nss;
    logic mosi;
    logic miso;

    modport SlaveSpi (
        input  nss,
        input  mosi,
        output miso
    );

    modport MasterSpi (
        output nss,
        output mosi,
        input  miso
    );
endinterface

// File: rtl/serial_alu_slave.sv
// Serial-slave ALU: receives {op_2, op_1, op_code} LSB first, returns result plus Z/N/C/V flags.
// Optional trailing even-parity bit when SERIAL_ALU_PARITY_EN is defined.
module serial_alu_slave #(
    parameter int WIDTH = 8
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    serial_alu_slave_if.SlaveSpi     spi,
    output logic                     o_busy
);

    localparam int SH_BITS  = $clog2(WIDTH);
    localparam int REQ_BITS = 3 + 2 * WIDTH;
`ifdef SERIAL_ALU_PARITY_EN
    localparam int RSP_BITS = WIDTH + 5;
`else
    localparam int RSP_BITS = WIDTH + 4;
`endif
    // REQ_BITS is always the longer phase, so one counter serves both.
    localparam int CNT_W    = $clog2(REQ_BITS);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RECEIVING = 3'd1,
        OPERATE   = 3'd2,
        RESPOND   = 3'd3,
        SENDING   = 3'd4
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_next;
    logic                 sample_en;
    logic                 load_en;

    logic [REQ_BITS-1:0]  req;
    logic [WIDTH-1:0]     result;
    logic                 flag_z;
    logic                 flag_n;
    logic                 flag_c;
    logic                 flag_v;

    logic [2:0]           op_code;
    logic [WIDTH-1:0]     op_1;
    logic [WIDTH-1:0]     op_2;
    logic [SH_BITS-1:0]   sh_amt;
    logic [WIDTH:0]       alu_wide;
    logic [WIDTH-1:0]     alu_r;
    logic                 alu_c;
    logic                 alu_v;

    logic [RSP_BITS-1:0]  rsp;
    logic                 rsp_bit;

    assign op_code = req[2:0];
    assign op_1    = req[3 +: WIDTH];
    assign op_2    = req[3 + WIDTH +: WIDTH];
    assign sh_amt  = op_2[SH_BITS-1:0];

    // Shifting by an amount >= WIDTH already yields zero, which covers non-power-of-2 widths.
    always_comb begin
        alu_wide = '0;
        alu_r    = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        case (op_code)
            3'd0: begin
                alu_wide = {1'b0, op_1} + {1'b0, op_2};
                alu_r    = alu_wide[WIDTH-1:0];
                alu_c    = alu_wide[WIDTH];
                alu_v    = (op_1[WIDTH-1] == op_2[WIDTH-1]) && (alu_r[WIDTH-1] != op_1[WIDTH-1]);
            end
            3'd1: begin
                alu_wide = {1'b0, op_1} - {1'b0, op_2};
                alu_r    = alu_wide[WIDTH-1:0];
                alu_c    = alu_wide[WIDTH];
                alu_v    = (op_1[WIDTH-1] != op_2[WIDTH-1]) && (alu_r[WIDTH-1] != op_1[WIDTH-1]);
            end
            3'd2:    alu_r = op_1 & op_2;
            3'd3:    alu_r = op_1 | op_2;
            3'd4:    alu_r = op_1 ^ op_2;
            3'd5:    alu_r = op_1 << sh_amt;
            3'd6:    alu_r = op_1 >> sh_amt;
            default: alu_r = ($signed(op_1) < $signed(op_2)) ? WIDTH'(1) : '0;
        endcase
    end

`ifdef SERIAL_ALU_PARITY_EN
    assign rsp = {^{result, flag_z, flag_n, flag_c, flag_v}, flag_v, flag_c, flag_n, flag_z, result};
`else
    assign rsp = {flag_v, flag_c, flag_n, flag_z, result};
`endif

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        sample_en  = 1'b0;
        load_en    = 1'b0;
        // Deselect aborts any transaction; computed results stay but are never sent.
        if (state != IDLE && spi.nss) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_next = '0;
                    if (!spi.nss && spi.mosi) state_next = RECEIVING;
                end
                RECEIVING: begin
                    sample_en = 1'b1;
                    if (cnt == CNT_W'(REQ_BITS - 1)) begin
                        state_next = OPERATE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                OPERATE: begin
                    load_en    = 1'b1;
                    state_next = RESPOND;
                end
                RESPOND: begin
                    if (!spi.mosi) state_next = SENDING;
                end
                SENDING: begin
                    if (cnt == CNT_W'(RSP_BITS - 1)) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    always_comb begin
        rsp_bit = 1'b0;
        for (int i = 0; i < RSP_BITS; i++) begin
            if (cnt == CNT_W'(i)) rsp_bit = rsp[i];
        end
    end

    always_comb begin
        spi.miso = 1'b0;
        if (!spi.nss) begin
            case (state)
                RESPOND: spi.miso = 1'b1;
                SENDING: spi.miso = rsp_bit;
                default: spi.miso = 1'b0;
            endcase
        end
    end

    assign o_busy = (state != IDLE);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state  <= IDLE;
            cnt    <= '0;
            req    <= '0;
            result <= '0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
            flag_c <= 1'b0;
            flag_v <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (sample_en) begin
                for (int i = 0; i < REQ_BITS; i++) begin
                    if (cnt == CNT_W'(i)) req[i] <= spi.mosi;
                end
            end
            if (load_en) begin
                result <= alu_r;
                flag_z <= (alu_r == '0);
                flag_n <= alu_r[WIDTH-1];
                flag_c <= alu_c;
                flag_v <= alu_v;
            end
        end
    end

endmodule
